// File: rtl/persiana_pkg.sv
`default_nettype none
// ============================================================================
// Module   : persiana_pkg
// Purpose  : Shared types and helpers for the multi-position blind controller.
//            - estado_t  : FSM state encoding (3-bit)
//            - DIR_SUB / DIR_BAJ : pending-direction encoding
//            - onehot_idx : index of the set bit of a one-hot sensor vector
//            - multi_hot  : more than one sensor bit set
// Revision : 1.0 - initial release
// ============================================================================
package persiana_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SUBIENDO = 3'd1,
        BAJANDO  = 3'd2,
        PAUSA    = 3'd3,
        FALLA    = 3'd4
    } estado_t;

    localparam logic DIR_SUB = 1'b1;
    localparam logic DIR_BAJ = 1'b0;

    // Sensor vectors are zero-extended to 8 bits (NPOS <= 8) before use.
    // Only meaningful when exactly one bit is set; returns the highest set
    // bit otherwise, which callers never rely on.
    function automatic logic [2:0] onehot_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/persiana_temporizador.sv
`default_nettype none
// ============================================================================
// Module   : persiana_temporizador
// Purpose  : Loadable down-counter that saturates at zero. Used both for the
//            reversal dead time and for the motion watchdog.
// Ports    : reloj  - clock
//            reset  - asynchronous active-high reset (count cleared)
//            carga  - load strobe, takes precedence over counting
//            valor  - load value
//            cero   - count is zero
// Revision : 1.0 - initial release
// ============================================================================
module persiana_temporizador #(
    parameter int TW = 10
) (
    input  logic          reloj,
    input  logic          reset,
    input  logic          carga,
    input  logic [TW-1:0] valor,
    output logic          cero
);

    logic [TW-1:0] cnt;

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (carga) begin
            cnt <= valor;
        end else if (cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign cero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/persiana_multipos.sv
`default_nettype none
// ============================================================================
// Module   : persiana_multipos
// Purpose  : Moore controller driving one blind motor toward any of NPOS
//            sensor-marked positions, with homing, reversal dead time, motion
//            watchdog with latched fault, and retargeting while moving.
// Ports    : reloj, reset          - clock, asynchronous active-high reset
//            sens[NPOS]            - position sensors (bit 0 = bottom)
//            cmd_pos, cmd_valid    - target index and its one-cycle strobe
//            clr_falla             - fault clear strobe
//            subir, bajar          - motor up / down (registered)
//            moviendo              - motor is being driven
//            pos_actual, pos_valido- last sensor index seen and its validity
//            falla                 - latched fault
// Revision : 1.0 - initial release
// ============================================================================
module persiana_multipos
    import persiana_pkg::*;
#(
    parameter int NPOS  = 3,
    parameter int DEADT = 4,
    parameter int TMAX  = 1000,
    localparam int PW   = (NPOS > 2) ? $clog2(NPOS) : 1,
    localparam int TW   = $clog2(TMAX + 1)
) (
    input  logic            reloj,
    input  logic            reset,
    input  logic [NPOS-1:0] sens,
    input  logic [PW-1:0]   cmd_pos,
    input  logic            cmd_valid,
    input  logic            clr_falla,
    output logic            subir,
    output logic            bajar,
    output logic            moviendo,
    output logic [PW-1:0]   pos_actual,
    output logic            pos_valido,
    output logic            falla
);

    localparam logic [PW:0] NPOS_W = (PW + 1)'(NPOS);

    estado_t       state, state_n;
    logic [PW-1:0] target, target_n;
    logic          dir_pend, dir_n;
    logic          carga;
    logic [TW-1:0] valor;
    logic          cero;

    logic [7:0]    sens8;
    logic          multi, uno;
    logic [PW-1:0] idx, eff_pos;
    logic [2:0]    tgt3;
    logic          cmd_ok, new_idx, moving, up, want_up;

    always_comb begin
        sens8 = 8'd0;
        sens8[NPOS-1:0] = sens;
    end

    assign multi   = multi_hot(sens8);
    assign uno     = (sens8 != 8'd0) && !multi;
    assign idx     = PW'(onehot_idx(sens8));
    assign tgt3    = 3'(target);
    assign cmd_ok  = cmd_valid && ({1'b0, cmd_pos} < NPOS_W);
    assign moving  = (state == SUBIENDO) || (state == BAJANDO);
    assign up      = (state == SUBIENDO);
    assign new_idx = uno && (!pos_valido || (idx != pos_actual));
    // Best estimate of where the blind is right now.
    assign eff_pos = uno ? idx : pos_actual;

    persiana_temporizador #(.TW(TW)) u_tmr (
        .reloj (reloj),
        .reset (reset),
        .carga (carga),
        .valor (valor),
        .cero  (cero)
    );

    always_comb begin
        state_n  = state;
        target_n = target;
        dir_n    = dir_pend;
        want_up  = 1'b0;
        carga    = 1'b0;
        valor    = '0;

        if (state == FALLA) begin
            if (clr_falla) state_n = IDLE;
        end else if (multi) begin
            state_n = FALLA;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_ok) begin
                        target_n = cmd_pos;
                        if (!pos_valido)               state_n = BAJANDO;
                        else if (cmd_pos > pos_actual) state_n = SUBIENDO;
                        else if (cmd_pos < pos_actual) state_n = BAJANDO;
                    end
                end
                SUBIENDO, BAJANDO: begin
                    if (cero) begin
                        state_n = FALLA;
                    end else if (!pos_valido && uno) begin
                        // First sensor after homing: re-derive direction.
                        want_up = (target > idx);
                        if (idx == target) begin
                            state_n = IDLE;
                        end else if (want_up != up) begin
                            state_n = PAUSA;
                            dir_n   = want_up ? DIR_SUB : DIR_BAJ;
                        end
                    end else if (pos_valido && sens8[tgt3]) begin
                        state_n = IDLE;
                    end else if ((up && sens[NPOS-1]) || (!up && sens[0])) begin
                        state_n = IDLE;
                    end else if (cmd_ok) begin
                        target_n = cmd_pos;
                        if (pos_valido) begin
                            // Between sensors, a target equal to the last seen
                            // index lies behind the direction of travel.
                            want_up = up ? (cmd_pos > eff_pos) : !(cmd_pos < eff_pos);
                            if (uno && (idx == cmd_pos)) begin
                                state_n = IDLE;
                            end else if (want_up != up) begin
                                state_n = PAUSA;
                                dir_n   = want_up ? DIR_SUB : DIR_BAJ;
                            end
                        end
                    end
                end
                PAUSA: begin
                    if (cmd_ok) begin
                        target_n = cmd_pos;
                        if (uno && (idx == cmd_pos))  state_n = IDLE;
                        else if (cmd_pos > eff_pos)   dir_n = DIR_SUB;
                        else if (cmd_pos < eff_pos)   dir_n = DIR_BAJ;
                    end
                    if ((state_n == PAUSA) && cero) begin
                        state_n = (dir_n == DIR_SUB) ? SUBIENDO : BAJANDO;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // Dead time on entering PAUSA; watchdog on entering motion or on
        // reaching a sensor not seen before.
        if ((state_n == PAUSA) && (state != PAUSA)) begin
            carga = 1'b1;
            valor = TW'(DEADT - 1);
        end else if (((state_n == SUBIENDO) || (state_n == BAJANDO)) && (!moving || new_idx)) begin
            carga = 1'b1;
            valor = TW'(TMAX - 1);
        end
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            target     <= '0;
            dir_pend   <= DIR_BAJ;
            pos_actual <= '0;
            pos_valido <= 1'b0;
            subir      <= 1'b0;
            bajar      <= 1'b0;
            moviendo   <= 1'b0;
            falla      <= 1'b0;
        end else begin
            state    <= state_n;
            target   <= target_n;
            dir_pend <= dir_n;
            subir    <= (state_n == SUBIENDO);
            bajar    <= (state_n == BAJANDO);
            moviendo <= (state_n == SUBIENDO) || (state_n == BAJANDO);
            falla    <= (state_n == FALLA);
            // Tracking is frozen in FALLA so a clear always forces re-homing.
            if (state == FALLA) begin
                if (clr_falla) pos_valido <= 1'b0;
            end else if (uno) begin
                pos_actual <= idx;
                pos_valido <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_persiana_multipos.sv
`default_nettype none
// ============================================================================
// Module   : tb_persiana_multipos
// Purpose  : Self-checking bench for persiana_multipos (NPOS=3, DEADT=4,
//            TMAX=20): behavioural motor model compared every cycle plus
//            directed scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_persiana_multipos;

    localparam int NPOS  = 3;
    localparam int DEADT = 4;
    localparam int TMAX  = 20;
    localparam int PW    = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NPOS-1:0] sens = '0;
    logic [PW-1:0]   cmd_pos = '0;
    logic            cmd_valid = 1'b0;
    logic            clr_falla = 1'b0;
    logic            subir, bajar, moviendo, pos_valido, falla;
    logic [PW-1:0]   pos_actual;

    int checks = 0;
    int errors = 0;

    persiana_multipos #(.NPOS(NPOS), .DEADT(DEADT), .TMAX(TMAX)) dut (
        .reloj      (clk),
        .reset      (reset),
        .sens       (sens),
        .cmd_pos    (cmd_pos),
        .cmd_valid  (cmd_valid),
        .clr_falla  (clr_falla),
        .subir      (subir),
        .bajar      (bajar),
        .moviendo   (moviendo),
        .pos_actual (pos_actual),
        .pos_valido (pos_valido),
        .falla      (falla)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // motor: +1 up, -1 down, 0 stopped. pause>0 means dead time still to run.
    int m_motor, m_pend, m_pause, m_tgt, m_pos, m_wd;
    bit m_fault, m_valid;

    always @(posedge clk or posedge reset) begin
        int nb, idx, eff, want;
        bit cok, go;
        if (reset) begin
            m_motor = 0; m_pend = 0; m_pause = 0; m_tgt = 0;
            m_pos = 0; m_wd = 0; m_fault = 0; m_valid = 0;
        end else begin
            nb = 0; idx = 0;
            for (int i = 0; i < NPOS; i++) if (sens[i]) begin nb++; idx = i; end
            cok = cmd_valid && (int'(cmd_pos) < NPOS);
            if (m_fault) begin
                if (clr_falla) begin m_fault = 0; m_valid = 0; end
            end else if (nb > 1) begin
                m_fault = 1; m_motor = 0; m_pause = 0;
            end else begin
                if (m_motor != 0) begin
                    if (m_wd == TMAX - 1) begin
                        m_fault = 1; m_motor = 0;
                    end else if (!m_valid && nb == 1) begin
                        if (idx == m_tgt) m_motor = 0;
                        else begin
                            want = (m_tgt > idx) ? 1 : -1;
                            if (want != m_motor) begin m_pend = want; m_pause = DEADT; m_motor = 0; end
                            else m_wd = 0;
                        end
                    end else if (m_valid && sens[m_tgt]) begin
                        m_motor = 0;
                    end else if ((m_motor > 0 && sens[NPOS-1]) || (m_motor < 0 && sens[0])) begin
                        m_motor = 0;
                    end else begin
                        go = 1;
                        if (cok) begin
                            m_tgt = int'(cmd_pos);
                            if (m_valid) begin
                                eff = (nb == 1) ? idx : m_pos;
                                if (nb == 1 && idx == m_tgt) begin m_motor = 0; go = 0; end
                                else begin
                                    if (m_motor > 0) want = (m_tgt > eff) ? 1 : -1;
                                    else             want = (m_tgt < eff) ? -1 : 1;
                                    if (want != m_motor) begin
                                        m_pend = want; m_pause = DEADT; m_motor = 0; go = 0;
                                    end
                                end
                            end
                        end
                        if (go) begin
                            if (nb == 1 && (idx != m_pos || !m_valid)) m_wd = 0;
                            else m_wd++;
                        end
                    end
                end else if (m_pause > 0) begin
                    go = 1;
                    if (cok) begin
                        m_tgt = int'(cmd_pos);
                        eff = (nb == 1) ? idx : m_pos;
                        if (nb == 1 && idx == m_tgt) begin m_pause = 0; go = 0; end
                        else if (m_tgt > eff) m_pend = 1;
                        else if (m_tgt < eff) m_pend = -1;
                    end
                    if (go) begin
                        m_pause--;
                        if (m_pause == 0) begin m_motor = m_pend; m_wd = 0; end
                    end
                end else if (cok) begin
                    m_tgt = int'(cmd_pos);
                    if (!m_valid)            begin m_motor = -1; m_wd = 0; end
                    else if (m_tgt > m_pos)  begin m_motor = 1;  m_wd = 0; end
                    else if (m_tgt < m_pos)  begin m_motor = -1; m_wd = 0; end
                end
                if (nb == 1) begin m_pos = idx; m_valid = 1; end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        check("subir",      int'(subir),      int'(m_motor == 1));
        check("bajar",      int'(bajar),      int'(m_motor == -1));
        check("moviendo",   int'(moviendo),   int'(m_motor != 0));
        check("falla",      int'(falla),      int'(m_fault));
        check("pos_valido", int'(pos_valido), int'(m_valid));
        check("pos_actual", int'(pos_actual), m_pos);
    end

    // ---------------- directed stimulus ----------------
    task automatic cmd(input int p);
        @(negedge clk);
        cmd_pos = PW'(p);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic count_low_until(input bit want_up, output int n);
        n = 0;
        while (!(want_up ? subir : bajar) && n < 20) begin
            if (subir || bajar) break;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_subir", int'(subir), 0);
        check("rst_pos_valido", int'(pos_valido), 0);
        check("rst_pos_actual", int'(pos_actual), 0);
        reset = 1'b0;

        // Homing toward top from unknown position
        cmd(2);
        check("home_bajar", int'(bajar), 1);
        repeat (2) @(negedge clk);
        sens = 3'b001;
        @(negedge clk);
        check("home_stop_bajar", int'(bajar), 0);
        check("home_valid", int'(pos_valido), 1);
        count_low_until(1'b1, n);
        check("home_deadtime", n, DEADT);
        check("home_subir", int'(subir), 1);
        sens = 3'b000;
        repeat (2) @(negedge clk);
        sens = 3'b100;
        @(negedge clk);
        check("home_arrive_subir", int'(subir), 0);
        check("home_pos2", int'(pos_actual), 2);

        // Go down to 0, then reversal on the way up
        cmd(0);
        check("down_bajar", int'(bajar), 1);
        sens = 3'b000;
        repeat (2) @(negedge clk);
        sens = 3'b001;
        @(negedge clk);
        check("down_stop", int'(bajar), 0);
        cmd(2);
        sens = 3'b000;
        repeat (2) @(negedge clk);
        cmd(0);
        check("rev_subir_drop", int'(subir), 0);
        count_low_until(1'b0, n);
        check("rev_deadtime", n, DEADT);
        check("rev_bajar", int'(bajar), 1);
        repeat (2) @(negedge clk);
        sens = 3'b001;
        @(negedge clk);
        check("rev_arrive", int'(bajar), 0);

        // Pass intermediate sensor, then retarget onto it
        cmd(2);
        sens = 3'b000;
        @(negedge clk);
        sens = 3'b010;
        @(negedge clk);
        check("mid_subir", int'(subir), 1);
        check("mid_pos1", int'(pos_actual), 1);
        cmd(1);
        check("mid_retarget_stop", int'(moviendo), 0);

        // Out-of-range command ignored
        cmd(3);
        check("ignore_cmd3", int'(moviendo), 0);

        // Watchdog timeout
        cmd(2);
        sens = 3'b000;
        n = 0;
        while (!falla && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TMAX);
        check("timeout_subir", int'(subir), 0);
        clr_falla = 1'b1;
        @(negedge clk);
        clr_falla = 1'b0;
        check("clr_falla", int'(falla), 0);
        check("clr_valid", int'(pos_valido), 0);

        // Multi-hot sensor error while homing
        cmd(0);
        sens = 3'b011;
        @(negedge clk);
        check("sens_err", int'(falla), 1);
        sens = 3'b001;
        clr_falla = 1'b1;
        @(negedge clk);
        clr_falla = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-motion
        cmd(2);
        sens = 3'b000;
        @(negedge clk);
        check("pre_reset_subir", int'(subir), 1);
        #3 reset = 1'b1;
        #1 check("async_reset_subir", int'(subir), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/persiana_multipos.md
# persiana_multipos

Parametrised successor to the three-position blind controller: drives one motor through `subir`/`bajar` toward any of `NPOS` sensor-marked positions. Compared with the three-position version it adds:
- a generic position count;
- homing after reset;
- a mandatory dead time on direction reversal;
- a motion timeout with a latched fault;
- mid-motion retargeting.

It sits between the command source (pushbuttons/UART decoder) and the motor driver. It is a Moore FSM with registered outputs.

## Interface
- `NPOS`, default 3: number of positions/sensors, 2..8; index 0 = bottom, `NPOS-1` = top.
- `DEADT`, default 4: cycles with both outputs low between opposite-direction drives, ≥1.
- `TMAX`, default 1000: max cycles in motion without reaching a new sensor, ≥2.
- Localparams: `PW = max(1,clog2(NPOS))`, `TW = clog2(TMAX+1)`.

Ports:
- `reloj` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sens` in NPOS: position sensors, 1 = blind at that position. Already synchronised upstream.
- `cmd_pos` in PW: target position index.
- `cmd_valid` in 1: one-cycle command strobe, sampled with `cmd_pos`.
- `clr_falla` in 1: fault-clear strobe.
- `subir` out 1: motor up.
- `bajar` out 1: motor down.
- `moviendo` out 1: high in SUBIENDO or BAJANDO.
- `pos_actual` out PW: last sensor index seen.
- `pos_valido` out 1: `pos_actual` is meaningful.
- `falla` out 1: latched fault.

## Operation
- States: IDLE, SUBIENDO, BAJANDO, PAUSA, FALLA. Registers: `target`, `pos_actual`, `pos_valido`, `dir_pend`, counter `cnt` (TW bits).
- **Output decoding:**
  - `subir = (state==SUBIENDO)`, `bajar = (state==BAJANDO)`; never both high.
  - `falla = (state==FALLA)`.
- **Sensor error:** more than one `sens` bit high in any non-FALLA state → FALLA.
- **Position tracking:** exactly one `sens` bit high → `pos_actual` takes its index and `pos_valido` is set. `pos_actual` holds when no bit is high.
- **Command acceptance:**
  - Ignored when `cmd_pos >= NPOS` or in FALLA.
  - In IDLE, otherwise accepted: `target <= cmd_pos`.
  - In IDLE with `pos_valido=1`: target above → SUBIENDO; below → BAJANDO; equal → stay IDLE.
- **Homing:** in IDLE with `pos_valido=0`, an accepted command → BAJANDO. On the first sensor hit, direction is recomputed from the rules above (same → continue, opposite → PAUSA, equal → IDLE).
- **Arrival:** in SUBIENDO/BAJANDO, when `sens[target]` is high → IDLE.
- **Limit safety:**
  - SUBIENDO with `sens[NPOS-1]` high → IDLE.
  - BAJANDO with `sens[0]` high → IDLE.
- **Retarget while moving:** a new valid command updates `target`.
  - Same direction or currently passing the target → continue or stop per the arrival rule.
  - Opposite direction → PAUSA with `dir_pend` set, `cnt=DEADT-1`.
  - `cmd_pos` equal to a sensor currently high → IDLE.
- **PAUSA:** both outputs low; count down to 0, then enter the `dir_pend` state. Commands received in PAUSA update `target` and `dir_pend`; `cnt` keeps running.
- **Timeout:** `cnt` is loaded with `TMAX-1` on entry to motion and on every newly seen sensor index. At 0 still moving → FALLA.
- **FALLA:** outputs low. `clr_falla` → IDLE with `pos_valido` cleared, which forces re-homing.
- **Simultaneous events, priority highest first:** sensor error > timeout > arrival/limit > `cmd_valid`. `clr_falla` outside FALLA is ignored.

## Timing
- **Reset values:** state IDLE; `subir=bajar=moviendo=falla=0`; `pos_actual=0`; `pos_valido=0`; `cnt=0`. Reset mid-motion drops the outputs asynchronously.
- **Start latency:** `cmd_valid` sampled at edge k → `subir`/`bajar` high from edge k, visible during cycle k+1.
- **Stop latency:** target sensor sampled high at edge k → motor output low after edge k.
- **Reversal:** the motor output drops at the edge that samples the reversing command. The opposite output rises exactly `DEADT` cycles later.
- **Timeout:** FALLA is entered `TMAX` edges after the last `cnt` reload with no new sensor.

## Structure
- Package `persiana_pkg` holds:
  - state encoding `estado_t` (3-bit);
  - direction constants `DIR_SUB`/`DIR_BAJ`;
  - helper functions `onehot_idx` and `multi_hot`.
- One natural sub-module: `persiana_temporizador`, a loadable TW-bit down-counter with a `cero` flag, shared by PAUSA dead time and motion timeout.
- The FSM and position tracker stay in the top module.

## Test plan
- Homing: reset, `sens=000`, `cmd_pos=2` → `bajar=1`. Then `sens=001` → `pos_valido=1`, `bajar=0`, `DEADT` idle cycles, `subir=1`. Then `sens=100` → `subir=0`, `pos_actual=2`.
- Reversal: moving up toward 2, `cmd_pos=0` → `subir=0` next cycle, exactly 4 cycles with both outputs low, then `bajar=1` until `sens[0]`.
- Intermediate stop and retarget: from 0, `cmd_pos=2`, `sens=010` passes (`pos_actual=1`, `subir` stays high). Then `cmd_pos=1` while `sens=010` → IDLE immediately.
- Timeout: `TMAX=20`, command up, no sensors → `falla=1` 20 cycles after start, outputs low. `clr_falla` → IDLE, `pos_valido=0`.
- Faults and filtering: `sens=011` while moving → FALLA next edge. `cmd_pos=3` with `NPOS=3` is ignored. `reset` asserted mid-motion → `subir=0` without waiting for a clock edge.
